// File: rtl/fpu_pkg.sv
// Shared types and helpers for the FP issue/sequencing controller.
package fpu_pkg;

  typedef enum logic [3:0] {
    FADD   = 4'b0000,
    FSUB   = 4'b0001,
    FMUL   = 4'b0010,
    FDIV   = 4'b0011,
    FSQRT  = 4'b0100,
    FSGNJ  = 4'b0101,
    FSGNJN = 4'b0110,
    FSGNJX = 4'b0111,
    FEQ    = 4'b1000,
    FLE    = 4'b1001,
    FLT    = 4'b1010,
    FCVTWS = 4'b1011,
    FCVTSW = 4'b1100
  } fpuop_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Encodings above FCVTSW have no unit behind them.
  function automatic logic is_illegal(input logic [3:0] op);
    return op > 4'(FCVTSW);
  endfunction

  // Cycles the unit bank needs before unit_result is valid; single-cycle ops
  // and illegal ops report 0.
  function automatic int unsigned op_latency(
    input logic [3:0]  op,
    input int unsigned lat_fadd,
    input int unsigned lat_fmul,
    input int unsigned lat_fdiv,
    input int unsigned lat_fsqrt,
    input int unsigned lat_fcvtws,
    input int unsigned lat_fcvtsw
  );
    case (op)
      4'(FADD), 4'(FSUB): return lat_fadd;
      4'(FMUL):           return lat_fmul;
      4'(FDIV):           return lat_fdiv;
      4'(FSQRT):          return lat_fsqrt;
      4'(FCVTWS):         return lat_fcvtws;
      4'(FCVTSW):         return lat_fcvtsw;
      default:            return 0;
    endcase
  endfunction

endpackage

// File: rtl/fpu_lat_cnt.sv
// Latency counter: loads a target on issue, counts while enabled, and flags
// the cycle in which the count has reached the target.
module fpu_lat_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_lat,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_lat;

  // Count holds once it reaches the target so it can never wrap.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= '0;
      r_lat <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
      r_lat <= i_lat;
    end else if (i_en && !o_done) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_done = i_en && (r_cnt == r_lat);

endmodule

// File: rtl/fpu_seq.sv
// Issue/sequencing controller between execute and the FP unit bank:
// latches one request, waits the op's latency, then holds the response.
module fpu_seq #(
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned LAT_FADD   = 3,
  parameter int unsigned LAT_FMUL   = 2,
  parameter int unsigned LAT_FDIV   = 11,
  parameter int unsigned LAT_FSQRT  = 7,
  parameter int unsigned LAT_FCVTWS = 1,
  parameter int unsigned LAT_FCVTSW = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             kill,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [31:0]      req_src0,
  input  logic [31:0]      req_src1,
  input  logic [TAG_W-1:0] req_tag,
  output logic [3:0]       unit_op,
  output logic [31:0]      unit_src0,
  output logic [31:0]      unit_src1,
  input  logic [31:0]      unit_result,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             busy
);

  import fpu_pkg::*;

  // A latency that does not fit the counter would never be reached.
  if (LAT_FADD >= 2**CNT_W || LAT_FMUL >= 2**CNT_W || LAT_FDIV >= 2**CNT_W ||
      LAT_FSQRT >= 2**CNT_W || LAT_FCVTWS >= 2**CNT_W || LAT_FCVTSW >= 2**CNT_W)
  begin : g_lat_chk
    $error("fpu_seq: every LAT_* must be < 2**CNT_W");
  end

  seq_state_e       r_state;
  seq_state_e       w_next;
  logic             w_accept;
  logic             w_done;
  logic             w_illegal;
  logic [CNT_W-1:0] w_lat;
  logic [3:0]       r_op;
  logic [31:0]      r_src0;
  logic [31:0]      r_src1;
  logic [TAG_W-1:0] r_tag;
  logic [TAG_W-1:0] r_resp_tag;
  logic [31:0]      r_result;
  logic             r_err;

  assign w_accept  = req_valid && req_ready;
  assign w_illegal = is_illegal(r_op);
  assign w_lat     = CNT_W'(op_latency(req_op, LAT_FADD, LAT_FMUL, LAT_FDIV,
                                       LAT_FSQRT, LAT_FCVTWS, LAT_FCVTSW));

  fpu_lat_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .rstn   (rstn),
    .i_clr  (kill),
    .i_load (w_accept),
    .i_en   (r_state == EXEC),
    .i_lat  (w_lat),
    .o_done (w_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next state: kill overrides everything; DONE can chain straight into EXEC.
  always_comb begin
    w_next = r_state;
    if (kill) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_next = EXEC;
        EXEC:    if (w_done)   w_next = DONE;
        DONE:    if (resp_ready) w_next = w_accept ? EXEC : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Handshake/status outputs decoded from the current state.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b0;
    if (!kill) req_ready = (r_state == IDLE) || (r_state == DONE && resp_ready);
    resp_valid = (r_state == DONE);
    busy       = (r_state != IDLE);
  end

  // Operand/tag latch on accept; result capture on the final EXEC cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_op       <= '0;
      r_src0     <= '0;
      r_src1     <= '0;
      r_tag      <= '0;
      r_resp_tag <= '0;
      r_result   <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= req_op;
        r_src0 <= req_src0;
        r_src1 <= req_src1;
        r_tag  <= req_tag;
      end
      if (r_state == EXEC && w_done && !kill) begin
        r_result   <= w_illegal ? 32'h0 : unit_result;
        r_err      <= w_illegal;
        r_resp_tag <= r_tag;
      end
    end
  end

  // fsub reuses the adder: hand it src1 with the sign flipped.
  assign unit_op     = r_op;
  assign unit_src0   = r_src0;
  assign unit_src1   = {r_src1[31] ^ (r_op == 4'(FSUB)), r_src1[30:0]};
  assign resp_result = r_result;
  assign resp_tag    = r_resp_tag;
  assign resp_err    = r_err;

endmodule
